exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage of the 5-stage pipelined core.
- Selects ALU operands with hazard-unit forwarding, runs the ALU, and registers the results plus control signals into the EX/MEM pipeline buffer.
- Sits between the ID/EX buffer and the memory stage.
- Stall via `en`; flush via `rst`.

Parameters:
- N, 16, datapath width in bits. Legal values are powers of two, at least 8.
- BUF_W, 4*N+18 (localparam, not overridable), EX/MEM buffer width. This is 82 at N=16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset/flush of the EX/MEM buffer
- en  in  1  buffer load enable; 0 = stall (hold)
- rd1  in  N  register read data for operand A
- rd2  in  N  register read data for operand B
- pc  in  N  instruction PC
- imm  in  N  extended immediate
- aluOut  in  N  EX/MEM ALU result (MEM-stage forward source)
- result  in  N  writeback value (WB-stage forward source)
- rd3  in  N  store data (register Rc contents)
- aluControl  in  4  ALU operation
- Ra, Rb, Rc  in  4 each  source A, source B and destination register numbers
- immSrc  in  1  1 = operand B is imm
- branchFlag  in  1  branch instruction; operand A is pc
- memWrite, memToReg, regWrite  in  1 each  control bits passed through to later stages
- Fa, Fb  in  2 each  forwarding selects from the hazard unit
- bufferOut  out  BUF_W  EX/MEM pipeline register

Behaviour:
- Forward mux, applied to A (from rd1, select Fa) and B (from rd2, select Fb):
  - 00 = register data
  - 01 = result
  - 10 = aluOut
  - 11 = register data
- Operand A: pc if branchFlag=1, otherwise the forwarded A.
- Operand B: imm if immSrc=1, otherwise the forwarded B.
- ALU operations by aluControl. All results are truncated to N bits.
  - 0 ADD, 1 SUB (A−B, wraps modulo 2^N)
  - 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[$clog2(N)-1:0]
  - 8 MUL, low N bits of the product
  - 9 SLT, signed; result is 1 if A<B else 0
  - 10 PASS B
  - 11–15 produce 0
- Flags (combinational):
  - zero = (ALU result == 0)
  - neg = ALU result MSB
- Buffer packing, MSB to LSB (82 bits total at N=16):
  - aluResult[N], storeData[N] (= rd3, unforwarded), pc[N], imm[N]
  - Rc[4], Ra[4], Rb[4]
  - zero, neg, branchFlag, memWrite, memToReg, regWrite
- Timing:
  - rst=1 clears bufferOut to all zeros immediately, independent of clk. This is the flush; a bubble has regWrite=memWrite=0.
  - Otherwise, on a rising clk edge with en=1, bufferOut loads the packed value. Latency is one cycle.
  - en=0 holds bufferOut unchanged.
- rst has priority over en.
- A reset asserted mid-operation discards the in-flight instruction.
- After rst deasserts, the next enabled edge loads normally.
- No combinational path exists from inputs to bufferOut.

Decomposition:
- Shared package `exec_pkg`:
  - ALU opcode enum `alu_op_t` (4-bit)
  - forward-select constants FWD_REG/FWD_WB/FWD_MEM
  - field offset localparams for the bufferOut layout, which the MEM stage also uses
- One sub-module `alu` (parameter N): inputs a, b, op; outputs y, zero, neg.
- The muxes and the buffer stay in `exec_stage`.

Test Plan (N=16):
- Reset: rst=1 with random inputs, no clock edge → bufferOut=0 at once. Release rst, en=1, ADD rd1=5 rd2=7 → aluResult=12, zero=0 after one edge.
- Forwarding: rd1=1, aluOut=0x0100, result=0x0020, rd2=3, SUB.
  - Fa=10 → 0x00FD
  - Fa=01 → 0x001D
  - Fa=11 → 0xFFFE (neg=1)
- Immediate/branch: branchFlag=1, pc=0x0040, immSrc=1, imm=0x0008, ADD → aluResult=0x0048. Control bits and Rc/Ra/Rb appear at their packed offsets.
- ALU edges:
  - SUB 0x8000−1 → 0x7FFF
  - SLT 0xFFFF vs 1 → 1
  - SRA 0x8000 by 0x0013 (amount 3) → 0xF000
  - MUL 0x0100×0x0100 → 0, zero=1
  - op 12 → 0
- Stall/flush: load a value, then en=0 for 3 edges with changing inputs → bufferOut held. Assert rst between edges → immediate 0 while en=0.

Source files
------------

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared types and constants for the execute stage: ALU
//               opcodes, forwarding selects and the EX/MEM buffer layout.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_MUL  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_t;

    // Forwarding selects driven by the hazard unit; 2'b11 behaves as FWD_REG.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX/MEM buffer bit offsets (LSB of each field). Fixed-width fields sit
    // at the bottom; the N-wide fields stack above them.
    localparam int OFF_REGWRITE = 0;
    localparam int OFF_MEMTOREG = 1;
    localparam int OFF_MEMWRITE = 2;
    localparam int OFF_BRANCH   = 3;
    localparam int OFF_NEG      = 4;
    localparam int OFF_ZERO     = 5;
    localparam int OFF_RB       = 6;
    localparam int OFF_RA       = 10;
    localparam int OFF_RC       = 14;
    localparam int OFF_IMM      = 18;

    function automatic int off_pc(input int n);
        return OFF_IMM + n;
    endfunction

    function automatic int off_store(input int n);
        return OFF_IMM + 2 * n;
    endfunction

    function automatic int off_alu(input int n);
        return OFF_IMM + 3 * n;
    endfunction

    function automatic int buf_width(input int n);
        return OFF_IMM + 4 * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : N-bit combinational ALU with zero and negative flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import exec_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_t      op,
    output logic [N-1:0] y,
    output logic         zero,
    output logic         neg
);

    localparam int SH_W = $clog2(N);

    logic [SH_W-1:0] w_shamt;
    logic [2*N-1:0]  w_product;
    logic            w_lt;

    assign w_shamt   = b[SH_W-1:0];
    assign w_product = a * b;
    assign w_lt      = ($signed(a) < $signed(b));

    // Operation select; unassigned opcodes yield zero.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << w_shamt;
            ALU_SRL:  y = a >> w_shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> w_shamt);
            ALU_MUL:  y = w_product[N-1:0];
            ALU_SLT:  y = {{(N-1){1'b0}}, w_lt};
            ALU_PASS: y = b;
            default:  y = '0;
        endcase
    end

    assign zero = (y == '0);
    assign neg  = y[N-1];

endmodule
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : exec_stage
// Description : Execute stage. Forwarded operand selection, ALU, and the
//               EX/MEM pipeline buffer (stall on en=0, async flush on rst).
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stage
    import exec_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     rd1,
    input  logic [N-1:0]     rd2,
    input  logic [N-1:0]     pc,
    input  logic [N-1:0]     imm,
    input  logic [N-1:0]     aluOut,
    input  logic [N-1:0]     result,
    input  logic [N-1:0]     rd3,
    input  logic [3:0]       aluControl,
    input  logic [3:0]       Ra,
    input  logic [3:0]       Rb,
    input  logic [3:0]       Rc,
    input  logic             immSrc,
    input  logic             branchFlag,
    input  logic             memWrite,
    input  logic             memToReg,
    input  logic             regWrite,
    input  logic [1:0]       Fa,
    input  logic [1:0]       Fb,
    output logic [4*N+17:0]  bufferOut
);

    localparam int BUF_W = 4 * N + 18;

    logic [N-1:0]     w_fwd_a;
    logic [N-1:0]     w_fwd_b;
    logic [N-1:0]     w_op_a;
    logic [N-1:0]     w_op_b;
    logic [N-1:0]     w_alu_y;
    logic             w_zero;
    logic             w_neg;
    logic [BUF_W-1:0] w_packed;

    // Forwarding muxes: WB result, MEM-stage ALU result, else register data.
    always_comb begin
        w_fwd_a = rd1;
        w_fwd_b = rd2;
        case (Fa)
            FWD_WB:  w_fwd_a = result;
            FWD_MEM: w_fwd_a = aluOut;
            default: w_fwd_a = rd1;
        endcase
        case (Fb)
            FWD_WB:  w_fwd_b = result;
            FWD_MEM: w_fwd_b = aluOut;
            default: w_fwd_b = rd2;
        endcase
    end

    // Branches compute a target from the PC; immediates replace operand B.
    assign w_op_a = branchFlag ? pc  : w_fwd_a;
    assign w_op_b = immSrc     ? imm : w_fwd_b;

    alu #(
        .N (N)
    ) u_alu (
        .a    (w_op_a),
        .b    (w_op_b),
        .op   (alu_op_t'(aluControl)),
        .y    (w_alu_y),
        .zero (w_zero),
        .neg  (w_neg)
    );

    // Store data is the raw rd3; any forwarding for it happens downstream.
    assign w_packed = {w_alu_y, rd3, pc, imm, Rc, Ra, Rb,
                       w_zero, w_neg, branchFlag, memWrite, memToReg, regWrite};

    // EX/MEM buffer: async flush to a bubble, load when enabled, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufferOut <= '0;
        end else if (en) begin
            bufferOut <= w_packed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_stage
// Description : Scoreboard testbench for exec_stage (N=16) with directed
//               vectors and hand-computed ALU results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_stage;

    localparam int N     = 16;
    localparam int BUF_W = 4 * N + 18;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [N-1:0]     rd1, rd2, pc, imm, aluOut, result, rd3;
    logic [3:0]       aluControl, Ra, Rb, Rc;
    logic             immSrc, branchFlag, memWrite, memToReg, regWrite;
    logic [1:0]       Fa, Fb;
    logic [BUF_W-1:0] bufferOut;

    typedef struct {
        string            name;
        logic [BUF_W-1:0] exp;
    } sb_item_t;

    sb_item_t         sb_q[$];
    logic [BUF_W-1:0] last_exp;
    int               checks = 0;
    int               errors = 0;

    exec_stage #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rd1        (rd1),
        .rd2        (rd2),
        .pc         (pc),
        .imm        (imm),
        .aluOut     (aluOut),
        .result     (result),
        .rd3        (rd3),
        .aluControl (aluControl),
        .Ra         (Ra),
        .Rb         (Rb),
        .Rc         (Rc),
        .immSrc     (immSrc),
        .branchFlag (branchFlag),
        .memWrite   (memWrite),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .Fa         (Fa),
        .Fb         (Fb),
        .bufferOut  (bufferOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BUF_W-1:0] act,
                         input logic [BUF_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the buffer updates on posedge, so compare shortly after it.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            check(it.name, bufferOut, it.exp);
        end
    end

    task automatic set_defaults();
        rst = 1'b0; en = 1'b1;
        rd1 = '0; rd2 = '0; pc = '0; imm = '0; aluOut = '0; result = '0;
        rd3 = '0; aluControl = 4'd0; Ra = '0; Rb = '0; Rc = '0;
        immSrc = 1'b0; branchFlag = 1'b0;
        memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
        Fa = 2'b00; Fb = 2'b00;
    endtask

    // Expected buffer: hand ALU value/flags plus the pass-through inputs.
    task automatic push(input string name, input logic [N-1:0] exp_alu,
                        input logic exp_zero, input logic exp_neg);
        sb_item_t it;
        it.name = name;
        it.exp  = {exp_alu, rd3, pc, imm, Rc, Ra, Rb,
                   exp_zero, exp_neg, branchFlag, memWrite, memToReg, regWrite};
        last_exp = it.exp;
        sb_q.push_back(it);
    endtask

    task automatic push_raw(input string name, input logic [BUF_W-1:0] exp);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic alu_vec(input string name, input logic [3:0] op,
                           input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] exp_alu,
                           input logic exp_zero, input logic exp_neg);
        @(negedge clk);
        set_defaults();
        aluControl = op; rd1 = a; rd2 = b;
        push(name, exp_alu, exp_zero, exp_neg);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_defaults();
        // Async reset with random inputs, before any clock edge.
        rst = 1'b1;
        rd1 = N'($urandom); rd2 = N'($urandom); pc = N'($urandom);
        imm = N'($urandom); rd3 = N'($urandom); regWrite = 1'b1;
        memWrite = 1'b1; Ra = 4'hF; Rb = 4'h7; Rc = 4'h9;
        #1;
        check("reset_async", bufferOut, '0);

        // First instruction after reset.
        alu_vec("add_5_7", 4'd0, 16'd5, 16'd7, 16'd12, 1'b0, 1'b0);

        // Forwarding variants on SUB.
        @(negedge clk); set_defaults();
        aluControl = 4'd1; rd1 = 16'd1; rd2 = 16'd3;
        aluOut = 16'h0100; result = 16'h0020; Fa = 2'b10;
        push("fwd_a_mem", 16'h00FD, 1'b0, 1'b0);
        @(negedge clk); Fa = 2'b01;
        push("fwd_a_wb", 16'h001D, 1'b0, 1'b0);
        @(negedge clk); Fa = 2'b11;
        push("fwd_a_reg11", 16'hFFFE, 1'b0, 1'b1);
        @(negedge clk); Fa = 2'b00; Fb = 2'b10;
        push("fwd_b_mem", 16'hFF01, 1'b0, 1'b1);

        // Branch target with immediate, plus all control/register fields.
        @(negedge clk); set_defaults();
        aluControl = 4'd0; branchFlag = 1'b1; pc = 16'h0040;
        immSrc = 1'b1; imm = 16'h0008; rd1 = 16'h1111; rd2 = 16'h2222;
        rd3 = 16'hBEEF; Rc = 4'hA; Ra = 4'h5; Rb = 4'h3;
        memWrite = 1'b1; memToReg = 1'b0; regWrite = 1'b1;
        push("branch_imm", 16'h0048, 1'b0, 1'b0);
        @(negedge clk);
        branchFlag = 1'b0; memWrite = 1'b0; memToReg = 1'b1; regWrite = 1'b0;
        rd1 = 16'h0002;
        push("imm_only", 16'h000A, 1'b0, 1'b0);

        // ALU edge cases and remaining operations.
        alu_vec("sub_wrap",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0);
        alu_vec("slt_neg",   4'd9,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
        alu_vec("slt_false", 4'd9,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        alu_vec("sra",       4'd7,  16'h8000, 16'h0013, 16'hF000, 1'b0, 1'b1);
        alu_vec("srl",       4'd6,  16'h8000, 16'h0003, 16'h1000, 1'b0, 1'b0);
        alu_vec("sll",       4'd5,  16'h0001, 16'h0014, 16'h0010, 1'b0, 1'b0);
        alu_vec("mul_ovf",   4'd8,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        alu_vec("mul",       4'd8,  16'h0012, 16'h0003, 16'h0036, 1'b0, 1'b0);
        alu_vec("and",       4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
        alu_vec("or",        4'd3,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b1);
        alu_vec("xor",       4'd4,  16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b1);
        alu_vec("pass_b",    4'd10, 16'hAAAA, 16'h1234, 16'h1234, 1'b0, 1'b0);
        alu_vec("op12",      4'd12, 16'h0005, 16'h0007, 16'h0000, 1'b1, 1'b0);
        alu_vec("op15",      4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0);

        // Stall: load, then hold for three edges while inputs change.
        @(negedge clk); set_defaults();
        aluControl = 4'd0; rd1 = 16'd2; rd2 = 16'd3; rd3 = 16'h5A5A;
        Rc = 4'h1; regWrite = 1'b1;
        push("stall_load", 16'h0005, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0;
            rd1 = N'($urandom); rd2 = N'($urandom); rd3 = N'($urandom);
            pc = N'($urandom); Rc = 4'($urandom); regWrite = ~regWrite;
            push_raw($sformatf("stall_hold%0d", i), last_exp);
        end

        // Flush between edges while stalled: clears without a clock edge.
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        #1;
        check("flush_async", bufferOut, '0);
        push_raw("flush_held", '0);

        // First enabled edge after flush loads normally.
        alu_vec("after_flush", 4'd0, 16'd5, 16'd7, 16'd12, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", BUF_W'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
